rgb_remote_pwm_multi: RTL and testbench

//  Parametrised successor of the remote RGB LED controller: CH-channel PWM LED driver with brightness,
//  on/off, palette-based FLASH/STROBE and an implemented SMOOTH (fade) mode. Sits behind the IR

---
 rtl/rgb_remote_pwm_multi_if.sv | 14 +
 rtl/rgb_remote_pwm_multi.sv | 229 ++++++++++++++++++++++
 tb/tb_rgb_remote_pwm_multi.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_remote_pwm_multi_if.sv
// Command bus between the IR decoder and the PWM LED controller.
// Handshake: cmd_valid high for one clk carries one command (cmd_op, cmd_data);
// there is no ready, so the receiver consumes it on that clock edge.
interface rgb_remote_pwm_multi_if #(
  parameter int CH  = 3,
  parameter int RES = 8
);
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [CH*RES-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data);
endinterface

// File: rtl/rgb_remote_pwm_multi.sv
// CH-channel PWM LED driver for the remote RGB controller: static colour,
// brightness, on/off, palette FLASH/STROBE and SMOOTH fade modes.
// Optional build macro RGB_REMOTE_GAMMA_EN adds a square-law gamma stage
// between brightness scaling and the duty latch.
// mode_o exposes the mode state register directly.
module rgb_remote_pwm_multi #(
  parameter int CH        = 3,
  parameter int RES       = 8,
  parameter int BRT_W     = 3,
  parameter int BRT_RST   = 5,
  parameter int PAL_DEPTH = 16,
  parameter int STEP_DIV  = 30_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_remote_pwm_multi_if.slave cmd,
  input  logic                  an,
  output logic [CH-1:0]         led_o,
  output logic                  sync_o,
  output logic [1:0]            mode_o,
  output logic                  light_on_o
);
  localparam int PW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = CH * RES;
  localparam logic [RES-1:0]   MAXV       = '1;
  localparam logic [BRT_W-1:0] BRT_MAX    = '1;
  localparam logic [SW-1:0]    PRESC_LAST = SW'(STEP_DIV - 1);

  localparam logic [2:0] OP_SET_COLOR = 3'd0;
  localparam logic [2:0] OP_BRT_UP    = 3'd1;
  localparam logic [2:0] OP_BRT_DOWN  = 3'd2;
  localparam logic [2:0] OP_OFF       = 3'd3;
  localparam logic [2:0] OP_ON        = 3'd4;
  localparam logic [2:0] OP_MODE_SET  = 3'd5;
  localparam logic [2:0] OP_MODE_NEXT = 3'd6;
  localparam logic [2:0] OP_PAL_PUSH  = 3'd7;

  typedef enum logic [1:0] {
    M_COLOR  = 2'd0,
    M_FLASH  = 2'd1,
    M_STROBE = 2'd2,
    M_SMOOTH = 2'd3
  } mode_t;

  mode_t              mode_q, mode_d, req_mode;
  logic               light_q, light_d;
  logic [BRT_W-1:0]   brt_q, brt_d;
  logic [CW-1:0]      static_q, static_d;
  logic [CW-1:0]      cur_q, cur_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [PW-1:0]      wptr_q;
  logic [SW-1:0]      presc_q, presc_d;
  logic [1:0]         scnt_q, scnt_d;
  logic [CW-1:0]      pal_q [PAL_DEPTH];

  logic [CW-1:0]      target, shown;
  logic               tick, all_eq;
  logic [RES-1:0]     c_v, t_v;
  logic [BRT_W:0]     brt_p1;
  logic [RES+BRT_W-1:0] prod;
  logic [CH-1:0][RES-1:0] eff, duty_src, duty_q;
  logic [RES-1:0]     cnt_q;
  logic [CH-1:0]      pwm_q;

  // Colour currently presented by the active mode, before brightness.
  always_comb begin
    target = pal_q[idx_q];
    case (mode_q)
      M_COLOR:  shown = static_q;
      M_FLASH:  shown = target;
      M_STROBE: shown = (scnt_q == 2'd0) ? target : '0;
      default:  shown = cur_q;
    endcase
  end

  // Next-state for mode, step timebase, palette index, fade value and settings.
  always_comb begin
    mode_d   = mode_q;
    light_d  = light_q;
    brt_d    = brt_q;
    static_d = static_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    scnt_d   = scnt_q;
    all_eq   = 1'b1;
    c_v      = '0;
    t_v      = '0;
    tick     = (mode_q != M_COLOR) && (presc_q == PRESC_LAST);

    req_mode = mode_q;
    if (cmd.cmd_valid && light_q) begin
      if (cmd.cmd_op == OP_MODE_SET)  req_mode = mode_t'(cmd.cmd_data[1:0]);
      if (cmd.cmd_op == OP_MODE_NEXT) req_mode = mode_t'(mode_q + 2'd1);
    end

    if (req_mode != mode_q) begin
      // A mode change restarts the sequence and swallows a coincident tick.
      mode_d  = req_mode;
      presc_d = '0;
      idx_d   = '0;
      scnt_d  = '0;
      if (req_mode == M_SMOOTH) cur_d = shown;
    end else begin
      presc_d = (mode_q == M_COLOR || tick) ? '0 : presc_q + 1'b1;
      if (tick) begin
        case (mode_q)
          M_FLASH: idx_d = idx_q + 1'b1;
          M_STROBE: begin
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == 2'd3) idx_d = idx_q + 1'b1;
          end
          M_SMOOTH: begin
            for (int i = 0; i < CH; i++) begin
              c_v = cur_q[i*RES +: RES];
              t_v = target[i*RES +: RES];
              if (c_v < t_v)      c_v = c_v + 1'b1;
              else if (c_v > t_v) c_v = c_v - 1'b1;
              cur_d[i*RES +: RES] = c_v;
              if (c_v != t_v) all_eq = 1'b0;
            end
            if (all_eq) idx_d = idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (cmd.cmd_valid) begin
      case (cmd.cmd_op)
        OP_SET_COLOR: if (light_q) static_d = cmd.cmd_data;
        OP_BRT_UP:    if (brt_q != BRT_MAX) brt_d = brt_q + 1'b1;
        OP_BRT_DOWN:  if (brt_q != '0) brt_d = brt_q - 1'b1;
        OP_OFF:       light_d = 1'b0;
        OP_ON:        light_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= M_COLOR;
      light_q  <= 1'b1;
      brt_q    <= BRT_W'(BRT_RST);
      static_q <= '1;
      cur_q    <= '0;
      idx_q    <= '0;
      presc_q  <= '0;
      scnt_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      light_q  <= light_d;
      brt_q    <= brt_d;
      static_q <= static_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      scnt_q   <= scnt_d;
    end
  end

  // Palette storage with a wrapping write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '0;
    end else if (cmd.cmd_valid && cmd.cmd_op == OP_PAL_PUSH) begin
      pal_q[wptr_q] <= cmd.cmd_data;
      wptr_q        <= wptr_q + 1'b1;
    end
  end

  // Brightness scaling: eff = val * (brt+1) / 2^BRT_W per channel.
  always_comb begin
    brt_p1 = {1'b0, brt_q} + 1'b1;
    prod   = '0;
    for (int i = 0; i < CH; i++) begin
      prod   = (RES+BRT_W)'(shown[i*RES +: RES]) * (RES+BRT_W)'(brt_p1);
      eff[i] = RES'(prod >> BRT_W);
    end
  end

`ifdef RGB_REMOTE_GAMMA_EN
  logic [CH-1:0][RES-1:0] eff_g_q;
  logic [2*RES-1:0]       sq;

  // Square-law gamma, registered; full scale stays full scale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eff_g_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sq = (2*RES)'(eff[i]) * (2*RES)'(eff[i]);
        eff_g_q[i] <= (eff[i] == MAXV) ? MAXV : RES'(sq >> RES);
      end
    end
  end

  // Duty latch source is the registered gamma value.
  always_comb duty_src = eff_g_q;
`else
  // Duty latch source is the linear brightness-scaled value.
  always_comb duty_src = eff;
`endif

  // PWM counter, duty latch at period start, registered comparator output.
  // duty changes on the edge where the counter wraps to 0, so each
  // counter period 0..max runs on a single duty value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == MAXV) duty_q <= duty_src;
      for (int i = 0; i < CH; i++)
        pwm_q[i] <= (duty_q[i] == MAXV) || (cnt_q < duty_q[i]);
    end
  end

  assign sync_o     = (cnt_q == '0);
  assign led_o      = light_q ? (pwm_q ^ {CH{an}}) : {CH{an}};
  assign mode_o     = mode_q;
  assign light_on_o = light_q;
endmodule

// File: tb/tb_rgb_remote_pwm_multi.sv
// Bench for rgb_remote_pwm_multi (RES=8, BRT_W=3, PAL_DEPTH=4, STEP_DIV=16).
// A command-level model tracks mode/brightness/palette/fade state in plain
// integers and predicts led_o/mode_o/light_on_o every cycle; PWM high counts
// over full periods are pinned against hand-computed values.
module tb_rgb_remote_pwm_multi;
  localparam int CH        = 3;
  localparam int RES       = 8;
  localparam int BRT_W     = 3;
  localparam int BRT_RST   = 5;
  localparam int PAL_DEPTH = 4;
  localparam int STEP_DIV  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic an  = 1'b0;
  logic [CH-1:0] led_o;
  logic          sync_o;
  logic [1:0]    mode_o;
  logic          light_on_o;

  always #5 clk = ~clk;

  rgb_remote_pwm_multi_if #(.CH(CH), .RES(RES)) cmd_if ();

  rgb_remote_pwm_multi #(
    .CH(CH), .RES(RES), .BRT_W(BRT_W), .BRT_RST(BRT_RST),
    .PAL_DEPTH(PAL_DEPTH), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .an         (an),
    .led_o      (led_o),
    .sync_o     (sync_o),
    .mode_o     (mode_o),
    .light_on_o (light_on_o)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode, m_on, m_brt, m_wptr, m_idx, m_presc, m_scnt, m_phase;
  int m_static[CH];
  int m_cur[CH];
  int m_duty[CH];
  int m_pal[PAL_DEPTH][CH];
  bit m_pwm[CH];

  function automatic int shown(input int ch);
    case (m_mode)
      0:       return m_static[ch];
      1:       return m_pal[m_idx][ch];
      2:       return (m_scnt == 0) ? m_pal[m_idx][ch] : 0;
      default: return m_cur[ch];
    endcase
  endfunction

  function automatic int scale(input int v);
    return (v * (m_brt + 1)) / (1 << BRT_W);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_on = 1; m_brt = BRT_RST; m_wptr = 0; m_idx = 0;
    m_presc = 0; m_scnt = 0; m_phase = 0;
    for (int c = 0; c < CH; c++) begin
      m_static[c] = 255; m_cur[c] = 0; m_duty[c] = 0; m_pwm[c] = 1'b0;
      for (int p = 0; p < PAL_DEPTH; p++) m_pal[p][c] = 0;
    end
  endtask

  // Model advances one clock: PWM output, period-start duty, then commands/ticks.
  always @(posedge clk) begin
    int new_mode;
    int snap[CH];
    bit tick, done;
    if (!rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_pwm[c] = (m_duty[c] == 255) || (m_phase < m_duty[c]);
        snap[c]  = shown(c);
      end
      if (m_phase == 255)
        for (int c = 0; c < CH; c++) m_duty[c] = scale(snap[c]);
      m_phase = (m_phase + 1) % 256;

      tick = (m_mode != 0) && (m_presc == STEP_DIV - 1);
      new_mode = m_mode;
      if (cmd_if.cmd_valid && m_on) begin
        if (cmd_if.cmd_op == 3'd5) new_mode = int'(cmd_if.cmd_data[1:0]);
        if (cmd_if.cmd_op == 3'd6) new_mode = (m_mode + 1) % 4;
      end
      if (new_mode != m_mode) begin
        if (new_mode == 3)
          for (int c = 0; c < CH; c++) m_cur[c] = snap[c];
        m_mode = new_mode; m_presc = 0; m_idx = 0; m_scnt = 0;
      end else begin
        m_presc = (m_mode == 0) ? 0 : (m_presc + 1) % STEP_DIV;
        if (tick) begin
          case (m_mode)
            1: m_idx = (m_idx + 1) % PAL_DEPTH;
            2: begin
              m_scnt = (m_scnt + 1) % 4;
              if (m_scnt == 0) m_idx = (m_idx + 1) % PAL_DEPTH;
            end
            3: begin
              done = 1'b1;
              for (int c = 0; c < CH; c++) begin
                if (m_cur[c] < m_pal[m_idx][c])      m_cur[c]++;
                else if (m_cur[c] > m_pal[m_idx][c]) m_cur[c]--;
                if (m_cur[c] != m_pal[m_idx][c]) done = 1'b0;
              end
              if (done) m_idx = (m_idx + 1) % PAL_DEPTH;
            end
            default: ;
          endcase
        end
      end

      if (cmd_if.cmd_valid) begin
        case (cmd_if.cmd_op)
          3'd0: if (m_on) for (int c = 0; c < CH; c++) m_static[c] = int'(cmd_if.cmd_data[c*8 +: 8]);
          3'd1: if (m_brt < 7) m_brt++;
          3'd2: if (m_brt > 0) m_brt--;
          3'd3: m_on = 0;
          3'd4: m_on = 1;
          3'd7: begin
            for (int c = 0; c < CH; c++) m_pal[m_wptr][c] = int'(cmd_if.cmd_data[c*8 +: 8]);
            m_wptr = (m_wptr + 1) % PAL_DEPTH;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [CH-1:0] exp_led;
    #2;
    if (chk_en) begin
      for (int c = 0; c < CH; c++)
        exp_led[c] = (rst && m_on) ? (m_pwm[c] ^ an) : an;
      check("led_o", 32'(led_o), 32'(exp_led));
      check("mode_o", 32'(mode_o), 32'(m_mode));
      check("light_on_o", 32'(light_on_o), 32'(m_on));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [23:0] data);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts active-high cycles per channel over one full PWM period,
  // skipping one period so earlier commands have reached the duty latch.
  task automatic measure(input string name, input int e0, input int e1, input int e2);
    int hi[CH];
    int guard;
    logic [8:0] e;
    exp_q.push_back(9'(e0));
    exp_q.push_back(9'(e1));
    exp_q.push_back(9'(e2));
    for (int s = 0; s < 2; s++) begin
      guard = 0;
      do begin
        @(posedge clk); #3; guard++;
      end while (!sync_o && guard < 600);
      if (!sync_o) begin
        checks++; errors++;
        $display("FAIL %s_sync: no sync_o within 600 clk", name);
        exp_q.delete();
        return;
      end
    end
    for (int c = 0; c < CH; c++) hi[c] = 0;
    repeat (256) begin
      @(posedge clk); #3;
      for (int c = 0; c < CH; c++) if (led_o[c] ^ an) hi[c]++;
    end
    for (int c = 0; c < CH; c++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_ch%0d_high", name, c), 32'(hi[c]), 32'(e));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    checks++; errors++;
    $display("FAIL watchdog: stimulus did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = '0;
    idle(3);
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset defaults: white, brightness 5 -> 191 of 256.
    check("rst_mode", 32'(mode_o), 32'd0);
    check("rst_light", 32'(light_on_o), 32'd1);
    measure("rst", 191, 191, 191);

    // Static colour and brightness saturation at both ends.
    send(3'd0, 24'hFF8000);
    repeat (5) send(3'd1, 24'h0);
    measure("color", 0, 128, 256);
    repeat (8) send(3'd2, 24'h0);
    measure("brt0", 0, 16, 31);
    repeat (7) send(3'd1, 24'h0);

    // OFF blanks immediately; SET_COLOR ignored while off.
    send(3'd3, 24'h0);
    check("off_light", 32'(light_on_o), 32'd0);
    check("off_led", 32'(led_o), 32'd0);
    send(3'd0, 24'h000010);
    send(3'd4, 24'h0);
    measure("on", 0, 128, 256);

    // FLASH over four palette entries, with an inverted-pin stretch.
    send(3'd7, 24'h0000FF);
    send(3'd7, 24'h00FF00);
    send(3'd7, 24'hFF0000);
    send(3'd7, 24'h404040);
    send(3'd5, 24'h000001);
    check("flash_mode", 32'(mode_o), 32'd1);
    idle(100);
    an = 1'b1;
    idle(80);
    an = 1'b0;
    send(3'd5, 24'h000001);
    idle(40);
    send(3'd3, 24'h0);
    send(3'd6, 24'h0);
    check("next_ignored_off", 32'(mode_o), 32'd1);
    send(3'd4, 24'h0);
    idle(300);

    // STROBE, then SMOOTH entered during the dark phase ramps 0 -> 5.
    repeat (4) send(3'd7, 24'h000005);
    send(3'd5, 24'h000002);
    check("strobe_mode", 32'(mode_o), 32'd2);
    idle(20);
    send(3'd6, 24'h0);
    check("smooth_mode", 32'(mode_o), 32'd3);
    idle(100);
    measure("smooth", 5, 0, 0);

    // Full-scale FLASH, then asynchronous reset mid-run.
    repeat (4) send(3'd7, 24'hFFFFFF);
    send(3'd5, 24'h000001);
    idle(300);
    check("pre_rst_led", 32'(led_o), 32'd7);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_led", 32'(led_o), 32'(an));
    check("async_rst_mode", 32'(mode_o), 32'd0);
    idle(2);
    rst = 1'b1;
    measure("rst2", 191, 191, 191);
    send(3'd5, 24'h000001);
    check("palclr_mode", 32'(mode_o), 32'd1);
    measure("palclr", 0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
